// File: rtl/aes_selftest_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_selftest_ctrl: known-answer and round-trip self test of an AES enc/dec pair
// Revision: 1.0
// ---------------------------------------------------------------------------
module aes_selftest_ctrl #(
   parameter int NK      = 4,
   parameter int NUM_VEC = 4,
   parameter int TIMEOUT = 1023
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                enc_start,
   output logic [127:0]        enc_msg,
   output logic [32*NK-1:0]    enc_key,
   output logic [32*NK-1:0]    dec_key,
   input  logic                enc_done,
   input  logic [127:0]        enc_data,
   output logic                dec_start,
   output logic [127:0]        dec_msg,
   input  logic                dec_done,
   input  logic [127:0]        dec_data,
   output logic                busy,
   output logic                pass,
   output logic                fail,
   output logic                timeout,
   output logic [7:0]          err_count,
   output logic [7:0]          vec_idx
);

   localparam int KW = 32 * NK;
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [127:0] MSG_BASE = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KAT = (NK == 8) ? 128'h8ea2b7ca516745bfeafc49904b496089 :
                                  (NK == 6) ? 128'hdda97ca4864cdfe06eaf70a0ec0d7191 :
                                              128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [7:0] LAST_IDX = 8'(NUM_VEC - 1);

   // Key bytes 00,01,02,... with byte 00 in the most significant position.
   function automatic logic [KW-1:0] key_base_f();
      logic [KW-1:0] r;
      r = '0;
      for (int i = 0; i < 4 * NK; i++) begin
         r[8*(4*NK-1-i) +: 8] = 8'(i);
      end
      return r;
   endfunction

   localparam logic [KW-1:0] KEY_BASE = key_base_f();

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ENC_REQ  = 3'd1,
      ENC_WAIT = 3'd2,
      DEC_REQ  = 3'd3,
      DEC_WAIT = 3'd4,
      CHECK    = 3'd5,
      DONE     = 3'd6
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      vec_idx_q, vec_idx_d;
   logic [7:0]      err_count_q, err_count_d;
   logic            busy_q, busy_d;
   logic            pass_q, pass_d;
   logic            fail_q, fail_d;
   logic            timeout_q, timeout_d;
   logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
   logic [127:0]    msg_q, msg_d;
   logic [127:0]    ct_q, ct_d;
   logic [127:0]    pt_q, pt_d;
   logic [KW-1:0]   key_q, key_d;
   logic            load_vec;
   logic            vec_err;
   logic            wait_expired;

   assign vec_err      = (pt_q != msg_q) || ((vec_idx_q == 8'd0) && (ct_q != KAT));
   assign wait_expired = (wait_cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      state_d     = state_q;
      vec_idx_d   = vec_idx_q;
      err_count_d = err_count_q;
      busy_d      = busy_q;
      pass_d      = pass_q;
      fail_d      = fail_q;
      timeout_d   = timeout_q;
      wait_cnt_d  = wait_cnt_q;
      msg_d       = msg_q;
      key_d       = key_q;
      ct_d        = ct_q;
      pt_d        = pt_q;
      load_vec    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = ENC_REQ;
               vec_idx_d   = 8'd0;
               err_count_d = 8'd0;
               pass_d      = 1'b0;
               fail_d      = 1'b0;
               timeout_d   = 1'b0;
               busy_d      = 1'b1;
               load_vec    = 1'b1;
            end
         end
         ENC_REQ: begin
            state_d    = ENC_WAIT;
            wait_cnt_d = '0;
         end
         ENC_WAIT: begin
            // A done in the expiry cycle still wins over the abort.
            if (enc_done) begin
               ct_d    = enc_data;
               state_d = DEC_REQ;
            end else if (wait_expired) begin
               timeout_d = 1'b1;
               fail_d    = 1'b1;
               busy_d    = 1'b0;
               state_d   = IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         DEC_REQ: begin
            state_d    = DEC_WAIT;
            wait_cnt_d = '0;
         end
         DEC_WAIT: begin
            if (dec_done) begin
               pt_d    = dec_data;
               state_d = CHECK;
            end else if (wait_expired) begin
               timeout_d = 1'b1;
               fail_d    = 1'b1;
               busy_d    = 1'b0;
               state_d   = IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         CHECK: begin
            if (vec_err && (err_count_q != 8'hff)) begin
               err_count_d = err_count_q + 8'd1;
            end
            if (vec_idx_q < LAST_IDX) begin
               vec_idx_d = vec_idx_q + 8'd1;
               load_vec  = 1'b1;
               state_d   = ENC_REQ;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            pass_d  = (err_count_q == 8'd0);
            fail_d  = (err_count_q != 8'd0);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (load_vec) begin
         msg_d = MSG_BASE + 128'(vec_idx_d);
         key_d = KEY_BASE + KW'(vec_idx_d);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         vec_idx_q   <= 8'd0;
         err_count_q <= 8'd0;
         busy_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         timeout_q   <= 1'b0;
         wait_cnt_q  <= '0;
         msg_q       <= '0;
         key_q       <= '0;
         ct_q        <= '0;
         pt_q        <= '0;
      end else begin
         state_q     <= state_d;
         vec_idx_q   <= vec_idx_d;
         err_count_q <= err_count_d;
         busy_q      <= busy_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         timeout_q   <= timeout_d;
         wait_cnt_q  <= wait_cnt_d;
         msg_q       <= msg_d;
         key_q       <= key_d;
         ct_q        <= ct_d;
         pt_q        <= pt_d;
      end
   end

   assign enc_start = (state_q == ENC_REQ);
   assign dec_start = (state_q == DEC_REQ);
   assign enc_msg   = msg_q;
   assign enc_key   = key_q;
   assign dec_key   = key_q;
   assign dec_msg   = ct_q;
   assign busy      = busy_q;
   assign pass      = pass_q;
   assign fail      = fail_q;
   assign timeout   = timeout_q;
   assign err_count = err_count_q;
   assign vec_idx   = vec_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_selftest_ctrl.sv
`default_nettype none
// tb_aes_selftest_ctrl: scoreboard bench driving aes_selftest_ctrl with XOR stand-in
// cipher cores whose vector-0 output equals the AES-128 known answer.
module tb_aes_selftest_ctrl;

   localparam int NK      = 4;
   localparam int NUM_VEC = 4;
   localparam int TIMEOUT = 15;
   localparam logic [127:0] MSG0 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KAT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C0   = KAT ^ MSG0 ^ KEY0;

   typedef struct packed { logic [7:0] idx; logic [127:0] msg; logic [127:0] key; } vec_t;
   typedef struct packed { logic [127:0] ct; logic [127:0] key; } ct_t;
   typedef struct packed { logic pass; logic fail; logic tmo; logic [7:0] err; } res_t;

   logic         clk = 1'b0;
   logic         rst, start;
   logic         enc_start, dec_start, enc_done, dec_done;
   logic [127:0] enc_msg, dec_msg, enc_data, dec_data;
   logic [127:0] enc_key, dec_key;
   logic         busy, pass, fail, timeout;
   logic [7:0]   err_count, vec_idx;

   vec_t exp_vec_q[$];
   ct_t  exp_ct_q[$];
   res_t exp_res_q[$];

   int n_cmp = 0;
   int n_err = 0;
   int n_enc = 0;
   int n_dec = 0;
   int enc_lat = 1;
   int dec_lat = 1;
   int flip_vec = -1;
   bit enc_never = 1'b0;
   bit dec_never = 1'b0;
   logic [127:0] skew = '0;

   aes_selftest_ctrl #(.NK(NK), .NUM_VEC(NUM_VEC), .TIMEOUT(TIMEOUT)) u_dut (
      .clk(clk), .rst(rst), .start(start),
      .enc_start(enc_start), .enc_msg(enc_msg), .enc_key(enc_key), .dec_key(dec_key),
      .enc_done(enc_done), .enc_data(enc_data),
      .dec_start(dec_start), .dec_msg(dec_msg), .dec_done(dec_done), .dec_data(dec_data),
      .busy(busy), .pass(pass), .fail(fail), .timeout(timeout),
      .err_count(err_count), .vec_idx(vec_idx)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] cipher(input logic [127:0] d, input logic [127:0] k);
      return d ^ k ^ C0 ^ skew;
   endfunction

   initial begin : enc_core
      logic [127:0] m, k;
      vec_t e;
      ct_t  c;
      enc_done = 1'b0;
      enc_data = '0;
      forever begin
         @(negedge clk);
         if (enc_start === 1'b1) begin
            n_enc++;
            m = enc_msg;
            k = enc_key;
            n_cmp++;
            if (exp_vec_q.size() == 0) begin
               n_err++;
               $display("FAIL enc_start_unexpected: got pulse at idx %0d, expected none", vec_idx);
            end else begin
               e = exp_vec_q.pop_front();
               if ({vec_idx, m, k} !== {e.idx, e.msg, e.key}) begin
                  n_err++;
                  $display("FAIL enc_req: got idx %0d msg %h key %h, expected idx %0d msg %h key %h",
                           vec_idx, m, k, e.idx, e.msg, e.key);
               end
               c.ct  = cipher(e.msg, e.key);
               c.key = e.key;
               exp_ct_q.push_back(c);
            end
            if (!enc_never) begin
               repeat (enc_lat) @(posedge clk);
               #1;
               enc_done = 1'b1;
               enc_data = cipher(m, k);
               @(posedge clk);
               #1;
               enc_done = 1'b0;
               enc_data = '0;
            end
         end
      end
   end

   initial begin : dec_core
      logic [127:0] c, k, kd, p;
      ct_t e;
      dec_done = 1'b0;
      dec_data = '0;
      forever begin
         @(negedge clk);
         if (dec_start === 1'b1) begin
            n_dec++;
            c = dec_msg;
            k = dec_key;
            n_cmp++;
            if (exp_ct_q.size() == 0) begin
               n_err++;
               $display("FAIL dec_start_unexpected: got pulse at idx %0d, expected none", vec_idx);
            end else begin
               e = exp_ct_q.pop_front();
               if ({c, k} !== {e.ct, e.key}) begin
                  n_err++;
                  $display("FAIL dec_req: got ct %h key %h, expected ct %h key %h", c, k, e.ct, e.key);
               end
            end
            kd = k - KEY0;
            p  = cipher(c, k);
            if (flip_vec >= 0 && kd == 128'(flip_vec)) p[0] = ~p[0];
            if (!dec_never) begin
               repeat (dec_lat) @(posedge clk);
               #1;
               dec_done = 1'b1;
               dec_data = p;
               @(posedge clk);
               #1;
               dec_done = 1'b0;
               dec_data = '0;
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation still running at 500000 ns, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic push_run(input int nvec, input res_t r);
      vec_t v;
      for (int i = 0; i < nvec; i++) begin
         v.idx = 8'(i);
         v.msg = MSG0 + 128'(i);
         v.key = KEY0 + 128'(i);
         exp_vec_q.push_back(v);
      end
      exp_res_q.push_back(r);
   endtask

   task automatic flush();
      exp_vec_q.delete();
      exp_ct_q.delete();
      exp_res_q.delete();
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (busy === 1'b1 && cyc < 1000) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic run_full(output int cyc, output res_t r);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle(cyc);
      r = exp_res_q.pop_front();
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({busy, pass, fail, timeout, enc_start, dec_start, err_count, vec_idx} !== 22'd0) begin
         n_err++;
         $display("FAIL reset_ctrl: got busy %b pass %b fail %b tmo %b es %b ds %b err %0d idx %0d, expected all 0",
                  busy, pass, fail, timeout, enc_start, dec_start, err_count, vec_idx);
      end
      n_cmp++;
      if ({enc_msg, dec_msg, enc_key, dec_key} !== 512'd0) begin
         n_err++;
         $display("FAIL reset_data: got msg %h dmsg %h key %h dkey %h, expected 0", enc_msg, dec_msg, enc_key, dec_key);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_good_run(input string name, input int lat);
      int cyc, exp_cyc;
      res_t r;
      enc_lat = lat;
      dec_lat = lat;
      n_enc = 0;
      n_dec = 0;
      exp_cyc = NUM_VEC * (2 * lat + 3) + 1;
      push_run(NUM_VEC, '{1'b1, 1'b0, 1'b0, 8'd0});
      run_full(cyc, r);
      n_cmp++;
      if (cyc != exp_cyc) begin
         n_err++;
         $display("FAIL %s_busy_cycles: got %0d, expected %0d", name, cyc, exp_cyc);
      end
      n_cmp++;
      if ({pass, fail, timeout, err_count} !== {r.pass, r.fail, r.tmo, r.err}) begin
         n_err++;
         $display("FAIL %s_result: got pass %b fail %b tmo %b err %0d, expected pass %b fail %b tmo %b err %0d",
                  name, pass, fail, timeout, err_count, r.pass, r.fail, r.tmo, r.err);
      end
      n_cmp++;
      if (n_enc != NUM_VEC || n_dec != NUM_VEC || vec_idx !== 8'(NUM_VEC - 1) || exp_vec_q.size() != 0) begin
         n_err++;
         $display("FAIL %s_pulses: got enc %0d dec %0d last idx %0d, expected %0d %0d %0d",
                  name, n_enc, n_dec, vec_idx, NUM_VEC, NUM_VEC, NUM_VEC - 1);
      end
      flush();
   endtask

   task automatic test_vector_error(input string name, input int flip, input logic [127:0] sk);
      int cyc;
      res_t r;
      enc_lat  = 1;
      dec_lat  = 1;
      flip_vec = flip;
      skew     = sk;
      push_run(NUM_VEC, '{1'b0, 1'b1, 1'b0, 8'd1});
      run_full(cyc, r);
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({pass, fail, timeout, err_count, busy} !== {r.pass, r.fail, r.tmo, r.err, 1'b0}) begin
         n_err++;
         $display("FAIL %s_result: got pass %b fail %b tmo %b err %0d busy %b, expected pass %b fail %b tmo %b err %0d busy 0",
                  name, pass, fail, timeout, err_count, busy, r.pass, r.fail, r.tmo, r.err);
      end
      flip_vec = -1;
      skew     = '0;
      flush();
   endtask

   task automatic test_timeout(input string name, input bit on_enc, input int exp_cyc);
      int cyc;
      res_t r;
      enc_lat   = 1;
      dec_lat   = 1;
      enc_never = on_enc;
      dec_never = !on_enc;
      push_run(1, '{1'b0, 1'b1, 1'b1, 8'd0});
      run_full(cyc, r);
      n_cmp++;
      if (cyc != exp_cyc) begin
         n_err++;
         $display("FAIL %s_cycles: got %0d busy cycles, expected %0d", name, cyc, exp_cyc);
      end
      n_cmp++;
      if ({pass, fail, timeout, err_count} !== {r.pass, r.fail, r.tmo, r.err}) begin
         n_err++;
         $display("FAIL %s_result: got pass %b fail %b tmo %b err %0d, expected pass %b fail %b tmo %b err %0d",
                  name, pass, fail, timeout, err_count, r.pass, r.fail, r.tmo, r.err);
      end
      enc_never = 1'b0;
      dec_never = 1'b0;
      flush();
      push_run(NUM_VEC, '{1'b1, 1'b0, 1'b0, 8'd0});
      run_full(cyc, r);
      n_cmp++;
      if ({pass, fail, timeout, err_count} !== {r.pass, r.fail, r.tmo, r.err}) begin
         n_err++;
         $display("FAIL %s_rerun: got pass %b fail %b tmo %b err %0d, expected pass %b fail %b tmo %b err %0d",
                  name, pass, fail, timeout, err_count, r.pass, r.fail, r.tmo, r.err);
      end
      flush();
   endtask

   task automatic test_reset_mid_run();
      int guard, bad;
      enc_lat = 1;
      dec_lat = 8;
      push_run(NUM_VEC, '{1'b1, 1'b0, 1'b0, 8'd0});
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (!(dec_start === 1'b1 && vec_idx === 8'd1) && guard < 200) begin
         guard++;
         @(negedge clk);
      end
      n_cmp++;
      if (guard >= 200) begin
         n_err++;
         $display("FAIL midrst_reach: got no DEC_REQ for idx 1 within %0d cycles, expected one", guard);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy, pass, fail, timeout, enc_start, dec_start, err_count, vec_idx} !== 22'd0) begin
         n_err++;
         $display("FAIL midrst_ctrl: got busy %b pass %b fail %b tmo %b err %0d idx %0d, expected all 0",
                  busy, pass, fail, timeout, err_count, vec_idx);
      end
      n_cmp++;
      if ({enc_msg, dec_msg, enc_key, dec_key} !== 512'd0) begin
         n_err++;
         $display("FAIL midrst_data: got msg %h dmsg %h key %h, expected 0", enc_msg, dec_msg, enc_key);
      end
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy !== 1'b0 || vec_idx !== 8'd0 || enc_start !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL midrst_resume: got %0d active cycles after release, expected 0", bad);
      end
      dec_lat = 1;
      flush();
   endtask

   task automatic test_back_to_back();
      int cyc;
      res_t r;
      enc_lat = 1;
      dec_lat = 1;
      n_enc = 0;
      n_dec = 0;
      push_run(NUM_VEC, '{1'b1, 1'b0, 1'b0, 8'd0});
      push_run(NUM_VEC, '{1'b1, 1'b0, 1'b0, 8'd0});
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      wait_idle(cyc);
      r = exp_res_q.pop_front();
      n_cmp++;
      if (cyc != 21 || {pass, fail, timeout, err_count} !== {r.pass, r.fail, r.tmo, r.err}) begin
         n_err++;
         $display("FAIL b2b_first: got cycles %0d pass %b fail %b, expected cycles 21 pass %b fail %b",
                  cyc, pass, fail, r.pass, r.fail);
      end
      @(negedge clk);
      n_cmp++;
      if ({busy, pass, fail, vec_idx} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
         n_err++;
         $display("FAIL b2b_second_start: got busy %b pass %b fail %b idx %0d, expected 1 0 0 0",
                  busy, pass, fail, vec_idx);
      end
      start = 1'b0;
      wait_idle(cyc);
      r = exp_res_q.pop_front();
      n_cmp++;
      if (cyc != 21 || {pass, fail, timeout, err_count} !== {r.pass, r.fail, r.tmo, r.err}) begin
         n_err++;
         $display("FAIL b2b_second: got cycles %0d pass %b fail %b, expected cycles 21 pass %b fail %b",
                  cyc, pass, fail, r.pass, r.fail);
      end
      n_cmp++;
      if (n_enc != 2 * NUM_VEC || n_dec != 2 * NUM_VEC) begin
         n_err++;
         $display("FAIL b2b_pulses: got enc %0d dec %0d, expected %0d each", n_enc, n_dec, 2 * NUM_VEC);
      end
      flush();
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      test_reset();
      test_good_run("zero_lat", 1);
      test_good_run("slow_cores", 12);
      test_good_run("done_at_limit", TIMEOUT);
      test_vector_error("decrypt_flip", 2, '0);
      test_vector_error("kat_wrong", -1, 128'h1);
      test_timeout("enc_timeout", 1'b1, TIMEOUT + 1);
      test_timeout("dec_timeout", 1'b0, TIMEOUT + 3);
      test_reset_mid_run();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
